// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: FSM encoding, RV32I
// size codes, timeout default and request legality helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = byte_off[0];
            2'b10:   bad = (byte_off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the LSB-justified core view and the word bus.
// Purely combinational: store enables/replication and load extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic        is_write,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rdata_shifted = rdata >> {byte_off, 3'b000};
        rd_byte       = rdata_shifted[7:0];
        rd_half       = rdata_shifted[15:0];
    end

    always_comb begin
        be          = 4'hF;
        wdata_lanes = '0;
        if (is_write) begin
            case (funct3)
                F3_B: begin
                    be          = 4'b0001 << byte_off;
                    wdata_lanes = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be          = 4'b0011 << byte_off;
                    wdata_lanes = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be          = 4'hF;
                    wdata_lanes = wdata;
                end
                default: begin
                    be          = 4'h0;
                    wdata_lanes = '0;
                end
            endcase
        end
    end

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    rdata_ext = {{16{rd_half[15]}}, rd_half};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'd0, rd_byte};
            F3_HU:   rdata_ext = {16'd0, rd_half};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store to word-wide req/ack bridge; stalls the pipeline via
// ramReady while a transaction is outstanding, faults bad or timed-out accesses.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic        ramReady,
    output logic [31:0] readData,
    output logic        accessFault,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        access_fault_q, access_fault_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        any_req;
    logic        both_req;
    logic        req_ok;
    logic        valid_req;
    logic        fault_req;
    logic [CW-1:0] cnt_inc;
    logic        timeout_hit;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    always_comb begin
        any_req   = memRead | memWrite;
        both_req  = memRead & memWrite;
        req_ok    = f3_legal(memWrite, funct3) && !misaligned(funct3, addr[1:0]);
        valid_req = any_req && !both_req && req_ok;
        fault_req = any_req && !valid_req;
    end

    always_comb begin
        cnt_inc     = cnt_q + CW'(1);
        timeout_hit = (cnt_inc == CW'(TIMEOUT));
    end

    // Lanes are driven from the captured request so the bus stays stable in BUSY.
    mem_lane_align u_lane_align (
        .funct3      (f3_q),
        .byte_off    (addr_q[1:0]),
        .is_write    (mem_we_q),
        .wdata       (wdata_q),
        .rdata       (memRdata),
        .be          (lane_be),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        access_fault_d = 1'b0;
        read_data_d    = read_data_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        f3_d           = f3_q;
        cnt_d          = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_req) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    mem_we_d  = memWrite;
                    addr_d    = addr;
                    wdata_d   = writeData;
                    f3_d      = funct3;
                    cnt_d     = '0;
                end else if (fault_req) begin
                    access_fault_d = 1'b1;
                    read_data_d    = '0;
                end
            end
            ST_BUSY: begin
                if (memAck) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        read_data_d = lane_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d        = ST_DONE;
                    mem_req_d      = 1'b0;
                    access_fault_d = 1'b1;
                    read_data_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                // Request inputs still show the finished instruction; ignore them.
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            access_fault_q <= 1'b0;
            read_data_q    <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            f3_q           <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            access_fault_q <= access_fault_d;
            read_data_q    <= read_data_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            f3_q           <= f3_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        ramReady = 1'b1;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: ramReady = ~valid_req;
                ST_BUSY: ramReady = 1'b0;
                ST_DONE: ramReady = 1'b1;
                default: ramReady = 1'b1;
            endcase
        end
    end

    always_comb begin
        readData    = read_data_q;
        accessFault = access_fault_q;
        memReq      = mem_req_q;
        memWe       = mem_we_q;
        memAddr     = {addr_q[31:2], 2'b00};
        memBe       = rst_n ? lane_be : 4'h0;
        memWdata    = rst_n ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a transaction-level reference
// model; directed cases cover the documented scenarios and reset abort.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic        ramReady;
    logic [31:0] readData;
    logic        accessFault;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .funct3      (funct3),
        .addr        (addr),
        .writeData   (writeData),
        .ramReady    (ramReady),
        .readData    (readData),
        .accessFault (accessFault),
        .memReq      (memReq),
        .memWe       (memWe),
        .memAddr     (memAddr),
        .memBe       (memBe),
        .memWdata    (memWdata),
        .memAck      (memAck),
        .memRdata    (memRdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_rd = 32'h0;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    int          seen_low;
    int          seen_req;
    int          seen_flt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_valid(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a);
        int sz;
        int off;
        sz  = acc_size(f3);
        off = int'(a[1:0]);
        if (rd == wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        return (off % sz) == 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int sz;
        logic [63:0] val;
        logic [63:0] mask;
        sz   = acc_size(f3);
        val  = {32'h0, w} >> (8 * int'(a[1:0]));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        val  = val & mask;
        if (!f3[2] && val[8*sz-1]) val = val | ~mask;
        return val[31:0];
    endfunction

    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                              input logic [31:0] rdat, input string tag);
        bit valid;
        bit fault;
        bit acked;
        bit finished;
        int exp_low, exp_req, exp_flt, sz;
        int low, req, flt, hold_bad, tail, cyc;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        valid    = is_valid(rd, wr, f3, a);
        fault    = (rd || wr) && !valid;
        acked    = valid && ack_at >= 1 && ack_at <= TO;
        exp_low  = valid ? 1 + (acked ? ack_at : TO) : 0;
        exp_req  = valid ? (acked ? ack_at : TO) : 0;
        exp_flt  = (fault || (valid && !acked)) ? 1 : 0;
        exp_addr = {a[31:2], 2'b00};
        sz       = (acc_size(f3) == 0) ? 1 : acc_size(f3);
        exp_be   = 4'hF;
        exp_wd   = 32'h0;
        if (wr) begin
            exp_be = 4'(((1 << sz) - 1) << int'(a[1:0]));
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        low = 0; req = 0; flt = 0; hold_bad = 0; tail = 0; cyc = 0; finished = 0;

        @(negedge clk);
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; writeData = wd;
        memAck = 1'b0; memRdata = $urandom();
        while (1) begin
            #1;
            if (memReq) begin
                req++;
                if (memAddr !== exp_addr || memBe !== exp_be || memWe !== wr ||
                    (wr && memWdata !== exp_wd)) hold_bad++;
                if (req == 1) begin
                    seen_addr = memAddr; seen_be = memBe; seen_wdata = memWdata; seen_we = memWe;
                end
                if (req == ack_at) begin
                    memAck = 1'b1; memRdata = rdat;
                end
            end
            if (accessFault) flt++;
            if (finished) tail++;
            else if (ramReady) finished = 1;
            else low++;
            if (tail == 2) break;
            cyc++;
            if (cyc > TO + 10) begin
                check_eq({tag, "_bound"}, 32'(cyc), 32'(TO + 10));
                break;
            end
            @(negedge clk);
            memAck = 1'b0; memRdata = $urandom();
            if (finished) begin
                memRead = 1'b0; memWrite = 1'b0;
                funct3 = 3'($urandom()); addr = $urandom(); writeData = $urandom();
                memAck = 1'($urandom_range(0, 1));
            end
        end

        if (fault || (valid && !acked)) model_rd = 32'h0;
        else if (acked && rd) model_rd = load_value(f3, a, rdat);

        seen_low = low; seen_req = req; seen_flt = flt;
        check_eq({tag, "_low"}, 32'(low), 32'(exp_low));
        check_eq({tag, "_req"}, 32'(req), 32'(exp_req));
        check_eq({tag, "_flt"}, 32'(flt), 32'(exp_flt));
        check_eq({tag, "_rdata"}, readData, model_rd);
        check_eq({tag, "_hold"}, 32'(hold_bad), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(ramReady), 32'h1);
        check_eq("rst_req", 32'(memReq), 32'h0);
        check_eq("rst_we", 32'(memWe), 32'h0);
        check_eq("rst_rdata", readData, 32'h0);
        check_eq("rst_fault", 32'(accessFault), 32'h0);
        check_eq("rst_be", 32'(memBe), 32'h0);
        check_eq("rst_wdata", memWdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, "lw");
        check_eq("lw_val", readData, 32'hDEADBEEF);
        check_eq("lw_addr", seen_addr, 32'h100);
        check_eq("lw_be", 32'(seen_be), 32'hF);
        check_eq("lw_stall", 32'(seen_low), 32'd4);

        run_access(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80000000, "lb");
        check_eq("lb_val", readData, 32'hFFFFFF80);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000, "lbu");
        check_eq("lbu_val", readData, 32'h00000080);

        run_access(0, 1, 3'b001, 32'h202, 32'h1234, 1, 32'h0, "sh");
        check_eq("sh_be", 32'(seen_be), 32'hC);
        check_eq("sh_wdata", seen_wdata, 32'h12341234);
        check_eq("sh_we", 32'(seen_we), 32'h1);
        check_eq("sh_once", 32'(seen_req), 32'h1);

        run_access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, "lw_mis");
        check_eq("mis_flt", 32'(seen_flt), 32'h1);
        check_eq("mis_req", 32'(seen_req), 32'h0);
        check_eq("mis_stall", 32'(seen_low), 32'h0);

        run_access(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h5555AAAA, "lw_pre");
        run_access(1, 0, 3'b010, 32'h108, 32'h0, 0, 32'h0, "lw_to");
        check_eq("to_stall", 32'(seen_low), 32'd9);
        check_eq("to_flt", 32'(seen_flt), 32'h1);
        check_eq("to_rdata", readData, 32'h0);

        // Reset during the second BUSY cycle abandons the transaction.
        run_access(1, 0, 3'b010, 32'h10C, 32'h0, 1, 32'hCAFEF00D, "lw_pre2");
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h300; memAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("ab_busy_req", 32'(memReq), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_eq("ab_req", 32'(memReq), 32'h0);
        check_eq("ab_ready", 32'(ramReady), 32'h1);
        check_eq("ab_be", 32'(memBe), 32'h0);
        check_eq("ab_wdata", memWdata, 32'h0);
        check_eq("ab_rdata", readData, 32'h0);
        rst_n = 1'b1; memRead = 1'b0; memAck = 1'b1; memRdata = 32'h12345678;
        @(negedge clk);
        memAck = 1'b0;
        #1;
        check_eq("late_req", 32'(memReq), 32'h0);
        check_eq("late_rdata", readData, 32'h0);
        check_eq("late_fault", 32'(accessFault), 32'h0);
        check_eq("late_ready", 32'(ramReady), 32'h1);
        model_rd = 32'h0;

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin rd = 1; wr = 0; end
            else if (r < 9) begin rd = 0; wr = 1; end
            else begin rd = 1'($urandom_range(0, 1)); wr = rd; end
            if ($urandom_range(0, 9) < 7) begin
                r  = int'($urandom_range(0, 4));
                f3 = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
            end else begin
                f3 = 3'($urandom());
            end
            a = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (acc_size(f3) == 2) a[0] = 1'b0;
                if (acc_size(f3) == 4) a[1:0] = 2'b00;
            end
            run_access(rd, wr, f3, a, $urandom(), int'($urandom_range(0, TO + 2)),
                       $urandom(), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Purpose: data-memory access stage. Converts MEM-stage load/store requests into a word-wide req/ack memory transaction and drives ramReady into the mode FSM. The mode FSM applies MASTER_HOLD = ~ramReady.

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles to wait for memAck before aborting.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 memRead  in  1  MEM-stage load request.
REQ-005 memWrite  in  1  MEM-stage store request.
REQ-006 funct3  in  3  RV32I size/sign code.
REQ-007 addr  in  32  byte address.
REQ-008 writeData  in  32  store data, LSB-justified.
REQ-009 ramReady  out  1  combinational; 0 = stall pipeline.
REQ-010 readData  out  32  registered load result, extended.
REQ-011 accessFault  out  1  one-cycle pulse: misaligned, illegal or timed-out access.
REQ-012 memReq  out  1  memory request, held until ack.
REQ-013 memWe  out  1  1 = write transaction.
REQ-014 memAddr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-015 memBe  out  4  byte enables; all 1s for reads.
REQ-016 memWdata  out  32  lane-shifted store data.
REQ-017 memAck  in  1  one-cycle completion strobe from memory.
REQ-018 memRdata  in  32  read word, valid when memAck=1.

Function
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE transitions:
- Valid request (exactly one of memRead/memWrite, legal funct3, aligned) -> BUSY.
- Otherwise stay in IDLE.
REQ-021 ramReady:
- IDLE: ~(valid request).
- BUSY: 0.
- DONE: 1.
REQ-022 BUSY behaviour:
- memReq=1 and memWe, memAddr, memBe, memWdata held stable.
- memAck=1 -> DONE; memReq drops the following cycle.
REQ-023 In DONE, request inputs are ignored; unconditional -> IDLE. This guarantees exactly one transaction per pipeline instruction.
REQ-024 Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010. Any other code is illegal.
REQ-025 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-026 Faulting requests: misaligned, illegal funct3, or memRead&memWrite both set.
- No memory transaction.
- accessFault pulses for exactly one cycle.
- ramReady stays 1.
- readData is set to 0.
REQ-027 Store enables: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<addr[1:0]; SW -> 4'b1111. memWdata = writeData replicated per lane.
REQ-028 Load extraction: byte/half selected by addr[1:0] from memRdata. Sign-extend for LB/LH, zero-extend for LBU/LHU. Result captured into readData on memAck; stores leave readData unchanged.
REQ-029 Timeout:
- A counter clears on BUSY entry and increments each BUSY cycle.
- On reaching TIMEOUT without ack -> DONE with accessFault=1 and readData=0.
- Width is clog2(TIMEOUT+1).
REQ-030 memAck outside BUSY is ignored.

Reset
REQ-031 rst_n=0 at an edge sets state=IDLE, memReq=0, memWe=0, readData=0, accessFault=0 and counter=0, including mid-BUSY; the abandoned transaction is not resumed.
REQ-032 During reset, ramReady=1, memBe=0, memWdata=0.

Structure
REQ-033 Shared package mem_pkg holds:
- state encoding.
- funct3 load/store constants.
- the TIMEOUT default.
REQ-034 Byte-lane logic (REQ-027/028) lives in the combinational sub-module mem_lane_align, instantiated once.

Verification
REQ-035 LW addr=0x100, ack after 3 cycles, memRdata=0xDEADBEEF -> ramReady low 4 cycles, readData=0xDEADBEEF, memAddr=0x100, memBe=4'hF.
REQ-036 LB addr=0x103, memRdata=0x80000000 -> readData=0xFFFFFF80. LBU at the same address -> readData=0x00000080.
REQ-037 SH addr=0x202, writeData=0x1234 -> memBe=4'b1100, memWdata=0x12341234, memWe=1, single transaction.
REQ-038 LW addr=0x101 -> accessFault one-cycle pulse, memReq never asserted, ramReady never low.
REQ-039 LW with no ack, TIMEOUT=8 -> ramReady low 9 cycles, accessFault=1, readData=0, then IDLE.
REQ-040 rst_n low on the second BUSY cycle -> next cycle memReq=0, state IDLE; a late memAck is ignored.
